// File: rtl/cbuf_rr_ctrl.sv
// -----------------------------------------------------------------------------
// cbuf_rr_ctrl
//   Front-end controller for a static circular buffer that has no internal
//   full/empty protection. It round-robin arbitrates NUMREQ producers onto the
//   single buffer push port and presents the buffer head to one consumer
//   through a valid/ready handshake. It tracks occupancy so the buffer is never
//   pushed when full or popped when empty, and it sequences a flush (drain).
//
// Optional feature macro: CBUF_CTRL_HWM_EN
//   When defined, adds output occ_hwm: the highest occupancy seen since reset
//   or since the last flush_done. When undefined, the port and register are
//   absent and all other behaviour is identical.
//
// Parameters
//   NUMELEM  buffer depth (must match the attached buffer)
//   BITDATA  element width (must match the attached buffer)
//   NUMREQ   number of producers, >= 2
//
// Ports
//   clk, rst    clock; synchronous active-high reset (also drives the buffer)
//   req_valid   per-producer data available
//   req_data    per-producer data, producer i at [i*BITDATA +: BITDATA]
//   req_ready   per-producer accept strobe (one-hot or zero)
//   buf_push    buffer push strobe
//   buf_din     buffer push data
//   buf_pop     buffer pop strobe
//   buf_dout    buffer head data
//   out_valid   head entry available to the consumer
//   out_data    head entry data (buf_dout passed through)
//   out_ready   consumer takes the head entry
//   flush       drain request, sampled only while running
//   flush_done  single-cycle pulse on the cycle the drain completes
//   occ         current occupancy, 0..NUMELEM
//   occ_hwm     occupancy high-water mark (CBUF_CTRL_HWM_EN only)
// -----------------------------------------------------------------------------
module cbuf_rr_ctrl #(
   parameter int NUMELEM = 4,
   parameter int BITDATA = 4,
   parameter int NUMREQ  = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUMREQ-1:0]           req_valid,
   input  logic [NUMREQ*BITDATA-1:0]   req_data,
   output logic [NUMREQ-1:0]           req_ready,
   output logic                        buf_push,
   output logic [BITDATA-1:0]          buf_din,
   output logic                        buf_pop,
   input  logic [BITDATA-1:0]          buf_dout,
   output logic                        out_valid,
   output logic [BITDATA-1:0]          out_data,
   input  logic                        out_ready,
   input  logic                        flush,
   output logic                        flush_done,
   output logic [$clog2(NUMELEM):0]    occ
`ifdef CBUF_CTRL_HWM_EN
   ,
   output logic [$clog2(NUMELEM):0]    occ_hwm
`endif
);

   localparam int OCC_W = $clog2(NUMELEM) + 1;
   localparam int PTR_W = $clog2(NUMREQ);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic [BITDATA-1:0] req_word [NUMREQ];
   logic               grant_any;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   cand;
   logic               in_run;
   logic               in_flush;
   logic               occ_nz;
   logic               push_ok;

   for (genvar g = 0; g < NUMREQ; g++) begin : g_unpack
      assign req_word[g] = req_data[g*BITDATA +: BITDATA];
   end

   // Round-robin search starting just after the last granted producer.
   // Walking the offsets from farthest to nearest lets the nearest valid
   // requester overwrite any farther one, giving a priority order without
   // an early exit.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = NUMREQ; k >= 1; k--) begin
         cand = PTR_W'((int'(rr_ptr_q) + k) % NUMREQ);
         if (req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // All strobes are held low during the reset cycle regardless of state.
   assign in_run   = (state_q == ST_RUN)   && !rst;
   assign in_flush = (state_q == ST_FLUSH) && !rst;
   assign occ_nz   = (occ_q != '0);

   // No bypass: the head is only offered once it is actually in the buffer,
   // so out_valid depends on registered occupancy alone.
   assign out_valid = in_run & occ_nz;
   assign out_data  = buf_dout;

   // During a flush the head is discarded one entry per cycle.
   assign buf_pop = (out_valid & out_ready) | (in_flush & occ_nz);

   // A full buffer can still accept a push when the head leaves this cycle.
   assign push_ok  = (occ_q < OCC_W'(NUMELEM)) | buf_pop;
   assign buf_push = in_run & push_ok & grant_any;
   assign buf_din  = req_word[grant_idx];

   always_comb begin
      req_ready = '0;
      if (buf_push) req_ready[grant_idx] = 1'b1;
   end

   // In FLUSH with occ==1 the final entry is popped this cycle, so the drain
   // finishes now rather than one cycle later.
   assign flush_done = in_flush & (occ_q <= OCC_W'(1));

   assign occ = occ_q;

   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN && flush) state_d = ST_FLUSH;
      else if (flush_done)            state_d = ST_RUN;

      occ_d    = occ_q + OCC_W'(buf_push) - OCC_W'(buf_pop);
      rr_ptr_d = buf_push ? grant_idx : rr_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         occ_q    <= '0;
         rr_ptr_q <= PTR_W'(NUMREQ - 1);
      end else begin
         state_q  <= state_d;
         occ_q    <= occ_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef CBUF_CTRL_HWM_EN
   logic [OCC_W-1:0] hwm_q, hwm_d;

   // Tracks registered occupancy, so a new peak shows up one cycle after occ
   // rises. Completion of a flush starts a fresh measurement window.
   always_comb begin
      hwm_d = hwm_q;
      if (flush_done)         hwm_d = '0;
      else if (occ_q > hwm_q) hwm_d = occ_q;
   end

   always_ff @(posedge clk) begin
      if (rst) hwm_q <= '0;
      else     hwm_q <= hwm_d;
   end

   assign occ_hwm = hwm_q;
`endif

   a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
      buf_pop |-> (occ_q != '0));
   a_push_room: assert property (@(posedge clk) disable iff (rst)
      buf_push |-> ((occ_q < OCC_W'(NUMELEM)) || buf_pop));
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(req_ready));
   a_occ_bound: assert property (@(posedge clk) disable iff (rst)
      occ_q <= OCC_W'(NUMELEM));

endmodule

// File: tb/tb_cbuf_rr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cbuf_rr_ctrl
//   Directed bench for cbuf_rr_ctrl (NUMELEM=4, BITDATA=8, NUMREQ=3) with a
//   small circular-buffer model attached to the push/pop ports.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   5 units after the rising edge.
// -----------------------------------------------------------------------------
module tb_cbuf_rr_ctrl;

   localparam int NE = 4;
   localparam int BD = 8;
   localparam int NR = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*BD-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              buf_push;
   logic [BD-1:0]     buf_din;
   logic              buf_pop;
   logic [BD-1:0]     buf_dout;
   logic              out_valid;
   logic [BD-1:0]     out_data;
   logic              out_ready;
   logic              flush;
   logic              flush_done;
   logic [$clog2(NE):0] occ;
`ifdef CBUF_CTRL_HWM_EN
   logic [$clog2(NE):0] occ_hwm;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cbuf_rr_ctrl #(.NUMELEM(NE), .BITDATA(BD), .NUMREQ(NR)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .buf_push   (buf_push),
      .buf_din    (buf_din),
      .buf_pop    (buf_pop),
      .buf_dout   (buf_dout),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .flush      (flush),
      .flush_done (flush_done),
`ifdef CBUF_CTRL_HWM_EN
      .occ_hwm    (occ_hwm),
`endif
      .occ        (occ)
   );

   // Plain circular buffer with no guards, sharing the controller reset.
   logic [BD-1:0] bmem [NE];
   logic [1:0]    wp, rp;

   always @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (buf_push) begin
            bmem[wp] <= buf_din;
            wp       <= wp + 2'd1;
         end
         if (buf_pop) rp <= rp + 2'd1;
      end
   end

   assign buf_dout = bmem[rp];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 3'b111;
      req_data  = '0;
      out_ready = 1'b1;
      flush     = 1'b0;
      cyc();
      cyc();
      #4;
      // Reset cycle: every strobe suppressed even with requests present
      check_val("rst_req_ready",  req_ready, 0);
      check_val("rst_buf_push",   buf_push, 0);
      check_val("rst_buf_pop",    buf_pop, 0);
      check_val("rst_out_valid",  out_valid, 0);
      check_val("rst_flush_done", flush_done, 0);
      check_val("rst_occ",        occ, 0);
`ifdef CBUF_CTRL_HWM_EN
      check_val("rst_hwm",        occ_hwm, 0);
`endif

      // All producers valid, consumer stalled: grants 0,1,2,0 then full
      cyc();
      rst       = 1'b0;
      req_valid = 3'b111;
      out_ready = 1'b0;
      req_data  = {8'h12, 8'h11, 8'h10};
      #4;
      check_val("rr_g0_ready", req_ready, 3'b001);
      check_val("rr_g0_din",   buf_din, 8'h10);
      check_val("rr_g0_ovld",  out_valid, 0);
      cyc(); #4;
      check_val("rr_g1_ready", req_ready, 3'b010);
      check_val("rr_g1_occ",   occ, 1);
      check_val("rr_g1_odata", out_data, 8'h10);
      cyc(); #4;
      check_val("rr_g2_ready", req_ready, 3'b100);
      check_val("rr_g2_occ",   occ, 2);
      cyc(); #4;
      check_val("rr_g3_ready", req_ready, 3'b001);
      check_val("rr_g3_din",   buf_din, 8'h10);
      check_val("rr_g3_occ",   occ, 3);
      cyc(); #4;
      check_val("full_ready",  req_ready, 3'b000);
      check_val("full_push",   buf_push, 0);
      check_val("full_occ",    occ, 4);

      // Full with simultaneous pop and push from producer 1
      cyc();
      req_valid = 3'b010;
      req_data  = {8'h12, 8'h21, 8'h10};
      out_ready = 1'b1;
      #4;
      check_val("fpp_pop",   buf_pop, 1);
      check_val("fpp_push",  buf_push, 1);
      check_val("fpp_ready", req_ready, 3'b010);
      check_val("fpp_odata", out_data, 8'h10);
`ifdef CBUF_CTRL_HWM_EN
      check_val("fpp_hwm",   occ_hwm, 4);
`endif
      cyc();
      req_valid = 3'b000;
      #4;
      check_val("fpp_occ_after",  occ, 4);
      check_val("fpp_head_after", out_data, 8'h11);
      check_val("drain_pop",      buf_pop, 1);

      // Flush from occ=3
      cyc();
      out_ready = 1'b0;
      flush     = 1'b1;
      #4;
      check_val("fl_req_occ",   occ, 3);
      check_val("fl_req_head",  out_data, 8'h12);
      check_val("fl_req_pop",   buf_pop, 0);
      check_val("fl_req_done",  flush_done, 0);
      cyc();
      flush     = 1'b0;
      req_valid = 3'b111;
      out_ready = 1'b1;
      #4;
      check_val("fl1_pop",   buf_pop, 1);
      check_val("fl1_ovld",  out_valid, 0);
      check_val("fl1_ready", req_ready, 3'b000);
      check_val("fl1_push",  buf_push, 0);
      check_val("fl1_done",  flush_done, 0);
      check_val("fl1_occ",   occ, 3);
      cyc(); #4;
      check_val("fl2_pop",   buf_pop, 1);
      check_val("fl2_done",  flush_done, 0);
      check_val("fl2_occ",   occ, 2);
      cyc(); #4;
      check_val("fl3_pop",   buf_pop, 1);
      check_val("fl3_done",  flush_done, 1);
      check_val("fl3_ready", req_ready, 3'b000);
      check_val("fl3_occ",   occ, 1);
      cyc();
      req_valid = 3'b000;
      #4;
      check_val("flx_occ",  occ, 0);
      check_val("flx_ovld", out_valid, 0);
      check_val("flx_done", flush_done, 0);
`ifdef CBUF_CTRL_HWM_EN
      check_val("flx_hwm",  occ_hwm, 0);
`endif

      // Flush while empty: done pulses on the following cycle
      flush = 1'b1;
      #1;
      check_val("fe_req_done", flush_done, 0);
      cyc();
      flush = 1'b0;
      #4;
      check_val("fe_done", flush_done, 1);
      check_val("fe_pop",  buf_pop, 0);
      cyc(); #4;
      check_val("fe_after_done", flush_done, 0);

      // Empty buffer, push 0xA5 from producer 2: no bypass to the consumer
      req_valid = 3'b100;
      req_data  = {8'hA5, 8'h00, 8'h00};
      out_ready = 1'b1;
      #1;
      check_val("nb_ovld",  out_valid, 0);
      check_val("nb_ready", req_ready, 3'b100);
      check_val("nb_din",   buf_din, 8'hA5);
      check_val("nb_pop",   buf_pop, 0);
      cyc();
      req_valid = 3'b000;
      #4;
      check_val("nb_next_ovld",  out_valid, 1);
      check_val("nb_next_odata", out_data, 8'hA5);
      check_val("nb_next_occ",   occ, 1);

      // Only producer 1 valid: granted every cycle
      cyc();
      req_valid = 3'b010;
      req_data  = {8'h00, 8'h31, 8'h00};
      #4;
      check_val("solo_occ0",   occ, 0);
      check_val("solo_ready0", req_ready, 3'b010);
      cyc(); #4;
      check_val("solo_ready1", req_ready, 3'b010);
      check_val("solo_pop1",   buf_pop, 1);
      cyc(); #4;
      check_val("solo_ready2", req_ready, 3'b010);
      // Fairness: after serving 1, producer 2 goes before 1
      cyc();
      req_valid = 3'b110;
      #4;
      check_val("fair_first",  req_ready, 3'b100);
      cyc(); #4;
      check_val("fair_second", req_ready, 3'b010);

      // Reset while flushing with occ=2
      cyc();
      req_valid = 3'b001;
      out_ready = 1'b0;
      #4;
      check_val("pre_rst_ready", req_ready, 3'b001);
      cyc();
      req_valid = 3'b000;
      flush     = 1'b1;
      #4;
      check_val("pre_rst_occ", occ, 2);
      cyc();
      flush = 1'b0;
      #4;
      check_val("mid_fl_pop", buf_pop, 1);
      rst = 1'b1;
      #1;
      check_val("mid_rst_pop", buf_pop, 0);
      cyc();
      rst       = 1'b0;
      req_valid = 3'b001;
      #4;
      check_val("post_rst_occ",   occ, 0);
      check_val("post_rst_ovld",  out_valid, 0);
      check_val("post_rst_done",  flush_done, 0);
      check_val("post_rst_ready", req_ready, 3'b001);
`ifdef CBUF_CTRL_HWM_EN
      check_val("post_rst_hwm",   occ_hwm, 0);
`endif

      cyc();
      req_valid = 3'b000;
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
